// File: rtl/cpu_pkg.sv
// Shared encodings for the PC/fetch sequencer: next-PC selects, FSM states, reset PC.
package cpu_pkg;

    localparam logic [2:0] NPC_SEQ  = 3'b000;
    localparam logic [2:0] NPC_BEQ  = 3'b001;
    localparam logic [2:0] NPC_BNE  = 3'b010;
    localparam logic [2:0] NPC_J    = 3'b011;
    localparam logic [2:0] NPC_JAL  = 3'b100;
    localparam logic [2:0] NPC_JR   = 3'b101;
    localparam logic [2:0] NPC_STOP = 3'b110;
    localparam logic [2:0] NPC_RSVD = 3'b111;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } fsm_state_e;

    localparam logic [31:0] CPU_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/pc_fetch_unit_npc_calc.sv
// Combinational next-PC selection and jal link value for the current instruction.
module npc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [2:0]  npc_sel,
    input  logic        zero,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    input  logic [31:0] jr_addr,
    output logic [31:0] next_pc,
    output logic [31:0] link_addr
);

    logic [31:0] p4;
    logic [31:0] br_target;

    assign p4        = pc + 32'd4;
    assign br_target = p4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign link_addr = p4;

    // Select the successor PC from the decoder's nPC_sel
    always_comb begin
        next_pc = p4;
        case (npc_sel)
            NPC_SEQ:         next_pc = p4;
            NPC_BEQ:         next_pc = zero  ? br_target : p4;
            NPC_BNE:         next_pc = !zero ? br_target : p4;
            NPC_J, NPC_JAL:  next_pc = {p4[31:28], target26, 2'b00};
            NPC_JR:          next_pc = jr_addr & 32'hFFFF_FFFC;
            NPC_STOP:        next_pc = pc;
            default:         next_pc = p4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch/exec/halt sequencer with fetch timeout and sticky error flags.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = CPU_RESET_PC,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  npc_sel,
    input  logic        zero,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    input  logic [31:0] jr_addr,
    input  logic        imem_valid,
    input  logic        resume,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic        commit,
    output logic [31:0] link_addr,
    output logic        halted,
    output logic        fetch_err,
    output logic        sel_err
);

    localparam int unsigned CW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FETCH_TIMEOUT - 1);

    fsm_state_e    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ferr_q, ferr_d;
    logic          serr_q, serr_d;
    logic [31:0]   next_pc;

    npc_calc u_npc_calc (
        .pc        (pc_q),
        .npc_sel   (npc_sel),
        .zero      (zero),
        .imm16     (imm16),
        .target26  (target26),
        .jr_addr   (jr_addr),
        .next_pc   (next_pc),
        .link_addr (link_addr)
    );

    // State, PC, timeout counter and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            ferr_q  <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            ferr_q  <= ferr_d;
            serr_q  <= serr_d;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        ferr_d   = ferr_q;
        serr_d   = serr_q;
        imem_req = 1'b0;
        commit   = 1'b0;
        halted   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    state_d = ST_EXEC;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HALT;
                    ferr_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_EXEC: begin
                commit = 1'b1;
                if (npc_sel == NPC_RSVD) serr_d = 1'b1;
                if (npc_sel == NPC_STOP) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d    = next_pc;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
                // Resume steps past the stop word so it is not re-executed
                if (resume) begin
                    pc_d    = link_addr;
                    ferr_d  = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign pc        = pc_q;
    assign fetch_err = ferr_q;
    assign sel_err   = serr_q;

endmodule
